// File: rtl/dvp_pkg.sv
// -----------------------------------------------------------------------------
// dvp_pkg
// Shared definitions for the DVP test-pattern transmitter:
//   - pattern select codes
//   - the eight RGB565 colour-bar constants and a lookup helper
//   - the frame-timing FSM state encoding
//   - common counter width for the horizontal / vertical counters
// -----------------------------------------------------------------------------
package dvp_pkg;

    // Width of h_cnt / v_cnt; large enough for any practical line length
    // or line count of this camera interface.
    localparam int CNT_W = 16;

    // Pattern codes carried on pattern_sel.
    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    // Colour bars, left to right.
    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_BACK   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FRONT  = 3'd4
    } state_e;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_pattern_px.sv
// -----------------------------------------------------------------------------
// dvp_pattern_px
// Purely combinational pixel generator: maps an active-area coordinate and a
// pattern code to an RGB565 value. The caller registers the result.
//
// Ports:
//   x_i        active column (0 .. CAM_WIDTH-1)
//   y_i        active line   (0 .. CAM_HEIGHT-1)
//   pattern_i  pattern code (PAT_BARS / PAT_RAMP / PAT_CHECK / PAT_SOLID)
//   solid_i    RGB565 fill colour for PAT_SOLID
//   pixel_o    RGB565 pixel for (x_i, y_i)
// -----------------------------------------------------------------------------
module dvp_pattern_px
    import dvp_pkg::*;
#(
    parameter int CAM_WIDTH = 640
) (
    input  logic [CNT_W-1:0] x_i,
    input  logic [CNT_W-1:0] y_i,
    input  logic [1:0]       pattern_i,
    input  logic [15:0]      solid_i,
    output logic [15:0]      pixel_o
);

    localparam int BAR_W = CAM_WIDTH / 8;

    logic [CNT_W-1:0] bar_idx;
    logic [7:0]       gray;
    logic             unused_bits;

    // x is always below CAM_WIDTH, so the quotient fits in three bits.
    assign bar_idx = x_i / CNT_W'(BAR_W);

    // Ramp wraps every 256 columns; luminance spread over R, G, B fields.
    assign gray = x_i[7:0];

    assign unused_bits = ^{bar_idx[CNT_W-1:3], y_i[CNT_W-1:4], y_i[2:0]};

    always_comb begin
        pixel_o = 16'h0000;
        case (pattern_i)
            PAT_BARS:  pixel_o = bar_color(bar_idx[2:0]);
            PAT_RAMP:  pixel_o = {gray[7:3], gray[7:2], gray[7:3]};
            PAT_CHECK: pixel_o = (x_i[3] ^ y_i[3]) ? 16'hFFFF : 16'h0000;
            default:   pixel_o = solid_i;
        endcase
    end

endmodule

// File: rtl/dvp_pattern_gen.sv
// -----------------------------------------------------------------------------
// dvp_pattern_gen
// Camera-side DVP transmitter producing OV2640-style frame/line timing and a
// selectable RGB565 test pattern. Stands in for the physical sensor during
// bring-up and for self-checking of downstream filters.
//
// Ports:
//   PCLK         pixel clock (only clock)
//   RST          synchronous reset, active-high
//   en           run request, sampled in IDLE and on the last frame cycle
//   pattern_sel  0 bars, 1 gray ramp, 2 checkerboard, 3 solid
//   solid_color  RGB565 fill for pattern 3
//   VSYNC        low during sync lines
//   HREF         high during active pixels of active lines
//   pixel_valid  same as HREF, qualifies pixel_out
//   pixel_out    RGB565 pixel, zero outside active pixels
//   busy         high whenever a frame is in progress
//   frame_done   one-cycle pulse on the last cycle of the frame
//
// Frame = SYNC (V_SYNC_LINES) + BACK (V_BACK_LINES) + ACTIVE (CAM_HEIGHT)
//       + FRONT (V_FRONT_LINES) line periods of CAM_WIDTH+H_BLANK cycles.
// -----------------------------------------------------------------------------
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int CAM_WIDTH     = 640,
    parameter int CAM_HEIGHT    = 480,
    parameter int H_BLANK       = 144,
    parameter int V_SYNC_LINES  = 3,
    parameter int V_BACK_LINES  = 17,
    parameter int V_FRONT_LINES = 10
) (
    input  logic        PCLK,
    input  logic        RST,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        VSYNC,
    output logic        HREF,
    output logic        pixel_valid,
    output logic [15:0] pixel_out,
    output logic        busy,
    output logic        frame_done
);

    localparam int LINE_LEN = CAM_WIDTH + H_BLANK;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(LINE_LEN - 1);

    // Control state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    // Per-frame pattern configuration
    logic [1:0]       pat_q, pat_d;
    logic [15:0]      solid_q, solid_d;

    // Registered outputs and their next values
    logic             vsync_q, vsync_d;
    logic             href_q, href_d;
    logic             busy_q, busy_d;
    logic             fdone_q, fdone_d;
    logic [15:0]      pix_q, pix_d;

    logic [15:0]      px_val;
    logic             line_end;
    logic             state_last_line;

    // Number of line periods spent in each timed state.
    function automatic logic [CNT_W-1:0] state_lines(input state_e s);
        logic [CNT_W-1:0] n;
        case (s)
            ST_SYNC:   n = CNT_W'(V_SYNC_LINES);
            ST_BACK:   n = CNT_W'(V_BACK_LINES);
            ST_ACTIVE: n = CNT_W'(CAM_HEIGHT);
            ST_FRONT:  n = CNT_W'(V_FRONT_LINES);
            default:   n = '0;
        endcase
        return n;
    endfunction

    // Last cycle of the whole frame. Without a front porch the frame ends
    // on the last cycle of the last active line.
    function automatic logic is_frame_last(input state_e s,
                                           input logic [CNT_W-1:0] h,
                                           input logic [CNT_W-1:0] v);
        logic last;
        if (V_FRONT_LINES > 0) begin
            last = (s == ST_FRONT) && (h == H_LAST) &&
                   (v == CNT_W'(V_FRONT_LINES - 1));
        end else begin
            last = (s == ST_ACTIVE) && (h == H_LAST) &&
                   (v == CNT_W'(CAM_HEIGHT - 1));
        end
        return last;
    endfunction

    // ---- state register ----------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    always_ff @(posedge PCLK) begin
        pat_q   <= pat_d;
        solid_q <= solid_d;
    end

    // ---- next-state logic --------------------------------------------------
    always_comb begin
        state_d         = state_q;
        h_d             = h_q;
        v_d             = v_q;
        pat_d           = pat_q;
        solid_d         = solid_q;
        line_end        = (h_q == H_LAST);
        state_last_line = (v_q == state_lines(state_q) - CNT_W'(1));

        if (state_q == ST_IDLE) begin
            h_d = '0;
            v_d = '0;
            if (en) begin
                state_d = ST_SYNC;
            end
        end else begin
            h_d = line_end ? '0 : h_q + CNT_W'(1);
            if (line_end) begin
                if (state_last_line) begin
                    v_d = '0;
                    case (state_q)
                        ST_SYNC:   state_d = (V_BACK_LINES > 0) ? ST_BACK : ST_ACTIVE;
                        ST_BACK:   state_d = ST_ACTIVE;
                        ST_ACTIVE: begin
                            if (V_FRONT_LINES > 0) begin
                                state_d = ST_FRONT;
                            end else begin
                                state_d = en ? ST_SYNC : ST_IDLE;
                            end
                        end
                        ST_FRONT:  state_d = en ? ST_SYNC : ST_IDLE;
                        default:   state_d = ST_IDLE;
                    endcase
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end
        end

        // Pattern settings are frozen for the whole frame from SYNC entry.
        if ((state_d == ST_SYNC) && (state_q != ST_SYNC)) begin
            pat_d   = pattern_sel;
            solid_d = solid_color;
        end
    end

    // ---- pixel generator (fed from next-state coordinates) -----------------
    dvp_pattern_px #(
        .CAM_WIDTH (CAM_WIDTH)
    ) u_px (
        .x_i       (h_d),
        .y_i       (v_d),
        .pattern_i (pat_d),
        .solid_i   (solid_d),
        .pixel_o   (px_val)
    );

    // ---- output next values ------------------------------------------------
    // Decoded from next state so that the registered outputs line up with
    // the state the FSM is in, with pixel and HREF sharing the same register
    // stage.
    always_comb begin
        vsync_d = (state_d != ST_SYNC);
        href_d  = (state_d == ST_ACTIVE) && (h_d < CNT_W'(CAM_WIDTH));
        busy_d  = (state_d != ST_IDLE);
        fdone_d = is_frame_last(state_d, h_d, v_d);
        pix_d   = href_d ? px_val : 16'h0000;
    end

    // ---- output registers --------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (RST) begin
            vsync_q <= 1'b1;
            href_q  <= 1'b0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
            pix_q   <= 16'h0000;
        end else begin
            vsync_q <= vsync_d;
            href_q  <= href_d;
            busy_q  <= busy_d;
            fdone_q <= fdone_d;
            pix_q   <= pix_d;
        end
    end

    assign VSYNC       = vsync_q;
    assign HREF        = href_q;
    assign pixel_valid = href_q;
    assign pixel_out   = pix_q;
    assign busy        = busy_q;
    assign frame_done  = fdone_q;

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_dvp_pattern_gen
// Two instances: A is a small 16x4 frame for timing and colour-bar checks,
// B is 256x16 (no back porch) for the gray ramp and checkerboard. A frame
// reference model derives every output from the cycle offset within the frame.
// -----------------------------------------------------------------------------
module tb_dvp_pattern_gen;

    localparam int A_W = 16,  A_H = 4,  A_HB = 4, A_S = 1, A_B = 1, A_F = 1;
    localparam int B_W = 256, B_H = 16, B_HB = 4, B_S = 2, B_B = 0, B_F = 1;
    localparam logic [20:0] IDLE_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

    logic        PCLK;
    logic        RST;
    logic        en_a, en_b;
    logic [1:0]  sel_a, sel_b;
    logic [15:0] solid_a, solid_b;
    logic        vs_a, href_a, pv_a, busy_a, fd_a;
    logic        vs_b, href_b, pv_b, busy_b, fd_b;
    logic [15:0] px_a, px_b;

    int vectors = 0;
    int miscompares = 0;

    // Per-frame observations filled by run_frame.
    int vs_low, valid_cnt, bursts, fd_at, fd_cnt;
    logic [15:0] cap [16][256];

    dvp_pattern_gen #(
        .CAM_WIDTH(A_W), .CAM_HEIGHT(A_H), .H_BLANK(A_HB),
        .V_SYNC_LINES(A_S), .V_BACK_LINES(A_B), .V_FRONT_LINES(A_F)
    ) dut_a (
        .PCLK(PCLK), .RST(RST), .en(en_a), .pattern_sel(sel_a), .solid_color(solid_a),
        .VSYNC(vs_a), .HREF(href_a), .pixel_valid(pv_a), .pixel_out(px_a),
        .busy(busy_a), .frame_done(fd_a)
    );

    dvp_pattern_gen #(
        .CAM_WIDTH(B_W), .CAM_HEIGHT(B_H), .H_BLANK(B_HB),
        .V_SYNC_LINES(B_S), .V_BACK_LINES(B_B), .V_FRONT_LINES(B_F)
    ) dut_b (
        .PCLK(PCLK), .RST(RST), .en(en_b), .pattern_sel(sel_b), .solid_color(solid_b),
        .VSYNC(vs_b), .HREF(href_b), .pixel_valid(pv_b), .pixel_out(px_b),
        .busy(busy_b), .frame_done(fd_b)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic int pw(int d);  return d == 0 ? A_W  : B_W;  endfunction
    function automatic int ph(int d);  return d == 0 ? A_H  : B_H;  endfunction
    function automatic int phb(int d); return d == 0 ? A_HB : B_HB; endfunction
    function automatic int ps(int d);  return d == 0 ? A_S  : B_S;  endfunction
    function automatic int pb(int d);  return d == 0 ? A_B  : B_B;  endfunction
    function automatic int pf(int d);  return d == 0 ? A_F  : B_F;  endfunction

    function automatic int line_len(int d);
        return pw(d) + phb(d);
    endfunction

    function automatic int frame_len(int d);
        return (ps(d) + pb(d) + ph(d) + pf(d)) * line_len(d);
    endfunction

    function automatic logic [20:0] obs(int d);
        if (d == 0) return {vs_a, href_a, pv_a, busy_a, fd_a, px_a};
        else        return {vs_b, href_b, pv_b, busy_b, fd_b, px_b};
    endfunction

    task automatic drive(int d, logic e, logic [1:0] s, logic [15:0] c);
        if (d == 0) begin en_a = e; sel_a = s; solid_a = c; end
        else        begin en_b = e; sel_b = s; solid_b = c; end
    endtask

    // Expected RGB565 value at active coordinate (x, y).
    function automatic logic [15:0] ref_pixel(int pat, int x, int y, int w, logic [15:0] solid);
        logic [15:0] p;
        int bar, g;
        p = 16'h0000;
        case (pat)
            0: begin
                bar = (x * 8) / w;
                case (bar)
                    0: p = 16'hFFFF;
                    1: p = 16'hFFE0;
                    2: p = 16'h07FF;
                    3: p = 16'h07E0;
                    4: p = 16'hF81F;
                    5: p = 16'hF800;
                    6: p = 16'h001F;
                    default: p = 16'h0000;
                endcase
            end
            1: begin
                g = x % 256;
                p = 16'(((g / 8) * 2048) + ((g / 4) * 32) + (g / 8));
            end
            2: p = ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 16'hFFFF : 16'h0000;
            default: p = solid;
        endcase
        return p;
    endfunction

    // Expected {VSYNC, HREF, pixel_valid, busy, frame_done, pixel} at offset n
    // (n = 0 is the first SYNC cycle).
    function automatic logic [20:0] ref_frame(int d, int n, int pat, logic [15:0] solid);
        int L, line, col, y;
        logic vs, act, hr, fd;
        logic [15:0] pix;
        L    = line_len(d);
        line = n / L;
        col  = n % L;
        y    = line - ps(d) - pb(d);
        vs   = (line >= ps(d));
        act  = (y >= 0) && (y < ph(d));
        hr   = act && (col < pw(d));
        pix  = hr ? ref_pixel(pat, col, y, pw(d), solid) : 16'h0000;
        fd   = (n == frame_len(d) - 1);
        return {vs, hr, hr, 1'b1, fd, pix};
    endfunction

    // Runs one full frame on instance d, comparing every cycle with the model.
    task automatic run_frame(int d, int pat, logic [15:0] solid, bit started, bit scramble,
                             bit next_en, int next_pat, logic [15:0] next_solid);
        int flen, L, x, y;
        logic [20:0] got, exp;
        logic prev_v;
        flen = frame_len(d);
        L    = line_len(d);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 256; j++) cap[i][j] = 16'hDEAD;
        if (!started) begin
            drive(d, 1'b1, 2'(pat), solid);
            @(posedge PCLK); #1;
        end
        vs_low = 0; valid_cnt = 0; bursts = 0; fd_at = -1; fd_cnt = 0; prev_v = 1'b0;
        for (int n = 0; n < flen; n++) begin
            got = obs(d);
            exp = ref_frame(d, n, pat, solid);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL frame dut%0d n=%0d got=%h exp=%h", d, n, got, exp);
            end
            if (!got[20]) vs_low++;
            if (got[18]) begin
                valid_cnt++;
                if (!prev_v) bursts++;
                x = n % L;
                y = n / L - ps(d) - pb(d);
                if (x >= 0 && x < 256 && y >= 0 && y < 16) cap[y][x] = got[15:0];
            end
            prev_v = got[18];
            if (got[16]) begin fd_at = n; fd_cnt++; end
            if (n == flen - 1)
                drive(d, next_en, 2'(next_pat), next_solid);
            else if (scramble)
                drive(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
            else
                drive(d, 1'b0, 2'(pat), solid);
            @(posedge PCLK); #1;
        end
    endtask

    task automatic test_reset;
        logic [20:0] got;
        RST = 1'b1;
        drive(0, 1'b1, 2'd0, 16'h1234);
        drive(1, 1'b1, 2'd3, 16'h5678);
        repeat (3) begin
            @(posedge PCLK); #1;
            for (int d = 0; d < 2; d++) begin
                got = obs(d);
                vectors++;
                if (got !== IDLE_VEC) begin
                    miscompares++;
                    $display("FAIL reset_state dut%0d got=%h exp=%h", d, got, IDLE_VEC);
                end
            end
        end
        RST = 1'b0;
        drive(0, 1'b0, 2'd0, 16'h0);
        drive(1, 1'b0, 2'd0, 16'h0);
        repeat (3) begin
            @(posedge PCLK); #1;
            for (int d = 0; d < 2; d++) begin
                got = obs(d);
                vectors++;
                if (got !== IDLE_VEC) begin
                    miscompares++;
                    $display("FAIL idle_after_reset dut%0d got=%h exp=%h", d, got, IDLE_VEC);
                end
            end
        end
    endtask

    task automatic test_timing_and_bars;
        int xs [4];
        logic [15:0] cols [4];
        logic [20:0] got;
        xs = '{0, 2, 10, 15};
        cols = '{16'hFFFF, 16'hFFE0, 16'hF800, 16'h0000};
        run_frame(0, 0, 16'($urandom), 1'b0, 1'b0, 1'b0, 0, 16'h0);
        vectors++;
        if (vs_low !== 20) begin miscompares++; $display("FAIL vsync_low_cycles got=%0d exp=20", vs_low); end
        vectors++;
        if (valid_cnt !== 64) begin miscompares++; $display("FAIL valid_cycles got=%0d exp=64", valid_cnt); end
        vectors++;
        if (bursts !== 4) begin miscompares++; $display("FAIL valid_bursts got=%0d exp=4", bursts); end
        vectors++;
        if (fd_at !== 139 || fd_cnt !== 1) begin
            miscompares++;
            $display("FAIL frame_done_cycle got=%0d (count %0d) exp=139 (count 1)", fd_at, fd_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cap[1][xs[i]] !== cols[i]) begin
                miscompares++;
                $display("FAIL bars_x%0d got=%h exp=%h", xs[i], cap[1][xs[i]], cols[i]);
            end
        end
        repeat (5) begin
            got = obs(0);
            vectors++;
            if (got !== IDLE_VEC) begin
                miscompares++;
                $display("FAIL idle_after_frame got=%h exp=%h", got, IDLE_VEC);
            end
            @(posedge PCLK); #1;
        end
    endtask

    task automatic test_check_ramp;
        run_frame(1, 2, 16'h0, 1'b0, 1'b0, 1'b0, 0, 16'h0);
        vectors++;
        if (cap[0][0] !== 16'h0000) begin miscompares++; $display("FAIL check_0_0 got=%h exp=0000", cap[0][0]); end
        vectors++;
        if (cap[0][8] !== 16'hFFFF) begin miscompares++; $display("FAIL check_8_0 got=%h exp=ffff", cap[0][8]); end
        vectors++;
        if (cap[8][8] !== 16'h0000) begin miscompares++; $display("FAIL check_8_8 got=%h exp=0000", cap[8][8]); end
        vectors++;
        if (valid_cnt !== B_W * B_H) begin
            miscompares++; $display("FAIL check_valid_cycles got=%0d exp=%0d", valid_cnt, B_W * B_H);
        end
        run_frame(1, 1, 16'h0, 1'b0, 1'b0, 1'b0, 0, 16'h0);
        vectors++;
        if (cap[0][255] !== 16'hFFFF) begin miscompares++; $display("FAIL ramp_x255 got=%h exp=ffff", cap[0][255]); end
        vectors++;
        if (cap[5][16] !== 16'h1082) begin miscompares++; $display("FAIL ramp_x16 got=%h exp=1082", cap[5][16]); end
    endtask

    task automatic test_midframe_change;
        logic [20:0] got;
        run_frame(0, 0, 16'h0, 1'b0, 1'b1, 1'b0, 2, 16'h0);
        vectors++;
        if (fd_at !== 139) begin miscompares++; $display("FAIL midframe_done got=%0d exp=139", fd_at); end
        repeat (3) begin
            got = obs(0);
            vectors++;
            if (got !== IDLE_VEC) begin
                miscompares++; $display("FAIL midframe_idle got=%h exp=%h", got, IDLE_VEC);
            end
            @(posedge PCLK); #1;
        end
    endtask

    task automatic test_back_to_back;
        int p1, p2;
        logic [15:0] s1, s2;
        logic [20:0] got;
        p1 = $urandom_range(0, 3); s1 = 16'($urandom);
        p2 = $urandom_range(0, 3); s2 = 16'($urandom);
        run_frame(0, p1, s1, 1'b0, 1'b0, 1'b1, p2, s2);
        run_frame(0, p2, s2, 1'b1, 1'b0, 1'b0, 0, 16'h0);
        got = obs(0);
        vectors++;
        if (got !== IDLE_VEC) begin miscompares++; $display("FAIL b2b_idle got=%h exp=%h", got, IDLE_VEC); end
    endtask

    task automatic test_reset_midframe;
        int pat;
        logic [15:0] sc;
        logic [20:0] got, exp;
        pat = $urandom_range(0, 3); sc = 16'($urandom);
        drive(0, 1'b1, 2'(pat), sc);
        @(posedge PCLK); #1;
        drive(0, 1'b0, 2'(pat), sc);
        // Active line 2 of A starts at offset (S+B+2)*L.
        for (int n = 0; n <= (A_S + A_B + 2) * (A_W + A_HB) + 5; n++) begin
            got = obs(0);
            exp = ref_frame(0, n, pat, sc);
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL pre_reset n=%0d got=%h exp=%h", n, got, exp);
            end
            if (n == (A_S + A_B + 2) * (A_W + A_HB) + 5) RST = 1'b1;
            @(posedge PCLK); #1;
        end
        RST = 1'b0;
        for (int c = 0; c < 160; c++) begin
            got = obs(0);
            vectors++;
            if (got !== IDLE_VEC) begin
                miscompares++; $display("FAIL post_reset c=%0d got=%h exp=%h", c, got, IDLE_VEC);
            end
            @(posedge PCLK); #1;
        end
        run_frame(0, $urandom_range(0, 3), 16'($urandom), 1'b0, 1'b0, 1'b0, 0, 16'h0);
    endtask

    task automatic test_random_b;
        for (int f = 0; f < 2; f++)
            run_frame(1, $urandom_range(0, 3), 16'($urandom), 1'b0, 1'b1, 1'b0, 0, 16'h0);
    endtask

    initial begin
        RST = 1'b1;
        drive(0, 1'b0, 2'd0, 16'h0);
        drive(1, 1'b0, 2'd0, 16'h0);
        test_reset();
        test_timing_and_bars();
        test_check_ramp();
        test_midframe_change();
        test_back_to_back();
        test_reset_midframe();
        test_random_b();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
